// File: rtl/axi_portal_initiator.sv
`default_nettype none
// ============================================================================
// Module   : axi_portal_initiator
// Purpose  : Single-outstanding MAXIGP0 master. Turns enq requests into
//            AR/AW/W traffic and returns R/B (or timeout) responses.
// Revision : 1.0
// ============================================================================
module axi_portal_initiator #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        nRST,

    input  logic        req_enq__ENA,
    output logic        req_enq__RDY,
    input  logic        req_enq_write,
    input  logic [31:0] req_enq_addr,
    input  logic [3:0]  req_enq_len,
    input  logic [11:0] req_enq_id,

    input  logic        wdata_enq__ENA,
    output logic        wdata_enq__RDY,
    input  logic [31:0] wdata_enq_v,

    output logic        MAXIGP0_O_AR__ENA,
    output logic [31:0] MAXIGP0_O_AR_addr,
    output logic [11:0] MAXIGP0_O_AR_id,
    output logic [3:0]  MAXIGP0_O_AR_len,
    input  logic        MAXIGP0_O_AR__RDY,

    output logic        MAXIGP0_O_AW__ENA,
    output logic [31:0] MAXIGP0_O_AW_addr,
    output logic [11:0] MAXIGP0_O_AW_id,
    output logic [3:0]  MAXIGP0_O_AW_len,
    input  logic        MAXIGP0_O_AW__RDY,

    output logic        MAXIGP0_O_W__ENA,
    output logic [31:0] MAXIGP0_O_W_data,
    output logic [11:0] MAXIGP0_O_W_id,
    output logic        MAXIGP0_O_W_last,
    input  logic        MAXIGP0_O_W__RDY,

    input  logic        MAXIGP0_I_R__ENA,
    input  logic [31:0] MAXIGP0_I_R_data,
    input  logic [11:0] MAXIGP0_I_R_id,
    input  logic        MAXIGP0_I_R_last,
    input  logic [1:0]  MAXIGP0_I_R_resp,
    output logic        MAXIGP0_I_R__RDY,

    input  logic        MAXIGP0_I_B__ENA,
    input  logic [11:0] MAXIGP0_I_B_id,
    input  logic [1:0]  MAXIGP0_I_B_resp,
    output logic        MAXIGP0_I_B__RDY,

    output logic        rsp_enq__ENA,
    output logic [31:0] rsp_enq_data,
    output logic [11:0] rsp_enq_id,
    output logic        rsp_enq_write,
    output logic        rsp_enq_last,
    output logic        rsp_enq_err,
    input  logic        rsp_enq__RDY,

    output logic        busy,
    output logic [7:0]  errCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RADDR = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WADDR = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;
    localparam logic [2:0] S_WRESP = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;

    localparam logic [31:0] c_abort_data = 32'hDEAD_BEEF;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [11:0] r_id;
    logic        r_write;
    logic [3:0]  r_cnt;
    logic [31:0] r_timer;
    logic [7:0]  r_err_count;

    logic w_in_rdata;
    logic w_in_wdata;
    logic w_in_wresp;
    logic w_req_hs;
    logic w_ar_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_b_hs;
    logic w_chan_hs;
    logic w_rsp_hs;
    logic w_last_beat;
    logic w_timeout;

    // The beat counter, not R last, decides where a read burst ends.
    logic w_unused_r_last;
    assign w_unused_r_last = MAXIGP0_I_R_last;

    assign w_in_rdata  = (r_state == S_RDATA);
    assign w_in_wdata  = (r_state == S_WDATA);
    assign w_in_wresp  = (r_state == S_WRESP);
    assign w_last_beat = (r_cnt == r_len);
    assign w_timeout   = (TIMEOUT != 0) && (r_timer == TIMEOUT - 32'd1);

    assign req_enq__RDY = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign errCount     = r_err_count;

    assign MAXIGP0_O_AR__ENA = (r_state == S_RADDR);
    assign MAXIGP0_O_AR_addr = r_addr;
    assign MAXIGP0_O_AR_id   = r_id;
    assign MAXIGP0_O_AR_len  = r_len;

    assign MAXIGP0_O_AW__ENA = (r_state == S_WADDR);
    assign MAXIGP0_O_AW_addr = r_addr;
    assign MAXIGP0_O_AW_id   = r_id;
    assign MAXIGP0_O_AW_len  = r_len;

    assign MAXIGP0_O_W__ENA  = w_in_wdata & wdata_enq__ENA;
    assign wdata_enq__RDY    = w_in_wdata & MAXIGP0_O_W__RDY;
    assign MAXIGP0_O_W_data  = w_in_wdata ? wdata_enq_v : 32'd0;
    assign MAXIGP0_O_W_id    = r_id;
    assign MAXIGP0_O_W_last  = w_in_wdata & w_last_beat;

    assign MAXIGP0_I_R__RDY  = w_in_rdata & rsp_enq__RDY;
    assign MAXIGP0_I_B__RDY  = w_in_wresp & rsp_enq__RDY;

    assign w_req_hs  = req_enq__ENA & req_enq__RDY;
    assign w_ar_hs   = MAXIGP0_O_AR__ENA & MAXIGP0_O_AR__RDY;
    assign w_aw_hs   = MAXIGP0_O_AW__ENA & MAXIGP0_O_AW__RDY;
    assign w_w_hs    = MAXIGP0_O_W__ENA & MAXIGP0_O_W__RDY;
    assign w_r_hs    = MAXIGP0_I_R__ENA & MAXIGP0_I_R__RDY;
    assign w_b_hs    = MAXIGP0_I_B__ENA & MAXIGP0_I_B__RDY;
    assign w_chan_hs = w_ar_hs | w_aw_hs | w_w_hs | w_r_hs | w_b_hs;
    assign w_rsp_hs  = rsp_enq__ENA & rsp_enq__RDY;

    // Response mux; the responder only echoes 6 id bits, so only those are compared.
    always_comb begin
        rsp_enq__ENA  = 1'b0;
        rsp_enq_data  = 32'd0;
        rsp_enq_id    = 12'd0;
        rsp_enq_write = 1'b0;
        rsp_enq_last  = 1'b0;
        rsp_enq_err   = 1'b0;
        case (r_state)
            S_RDATA: begin
                rsp_enq__ENA  = MAXIGP0_I_R__ENA;
                rsp_enq_data  = MAXIGP0_I_R_data;
                rsp_enq_id    = MAXIGP0_I_R_id;
                rsp_enq_last  = w_last_beat;
                rsp_enq_err   = (MAXIGP0_I_R_resp != 2'd0) |
                                (MAXIGP0_I_R_id[5:0] != r_id[5:0]);
            end
            S_WRESP: begin
                rsp_enq__ENA  = MAXIGP0_I_B__ENA;
                rsp_enq_id    = MAXIGP0_I_B_id;
                rsp_enq_write = 1'b1;
                rsp_enq_last  = 1'b1;
                rsp_enq_err   = (MAXIGP0_I_B_resp != 2'd0) |
                                (MAXIGP0_I_B_id[5:0] != r_id[5:0]);
            end
            S_ABORT: begin
                rsp_enq__ENA  = 1'b1;
                rsp_enq_data  = c_abort_data;
                rsp_enq_id    = r_id;
                rsp_enq_write = r_write;
                rsp_enq_last  = 1'b1;
                rsp_enq_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // A handshake on the timeout cycle takes priority over the abort.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_hs) begin
                    w_state_nxt = req_enq_write ? S_WADDR : S_RADDR;
                end
            end
            S_RADDR: begin
                if (w_ar_hs)        w_state_nxt = S_RDATA;
                else if (w_timeout) w_state_nxt = S_ABORT;
            end
            S_WADDR: begin
                if (w_aw_hs)        w_state_nxt = S_WDATA;
                else if (w_timeout) w_state_nxt = S_ABORT;
            end
            S_WDATA: begin
                if (w_w_hs) begin
                    if (w_last_beat) w_state_nxt = S_WRESP;
                end else if (w_timeout) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_WRESP: begin
                if (w_b_hs)         w_state_nxt = S_IDLE;
                else if (w_timeout) w_state_nxt = S_ABORT;
            end
            S_RDATA: begin
                if (w_r_hs) begin
                    if (w_last_beat) w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                if (w_rsp_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_len       <= 4'd0;
            r_id        <= 12'd0;
            r_write     <= 1'b0;
            r_cnt       <= 4'd0;
            r_timer     <= 32'd0;
            r_err_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_req_hs) begin
                r_addr  <= req_enq_addr;
                r_len   <= req_enq_len;
                r_id    <= req_enq_id;
                r_write <= req_enq_write;
                r_cnt   <= 4'd0;
            end else if (w_w_hs || w_r_hs) begin
                r_cnt <= r_cnt + 4'd1;
            end

            // Any state change (which covers entry into every busy state) restarts the timer.
            if ((w_state_nxt != r_state) || w_chan_hs) begin
                r_timer <= 32'd0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end

            if (w_rsp_hs && rsp_enq_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_portal_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_portal_initiator
// Purpose  : Directed scoreboard bench for axi_portal_initiator.
// Revision : 1.0
// ============================================================================
module tb_axi_portal_initiator;

    typedef struct packed {
        logic [31:0] data;
        logic [11:0] id;
        logic        write;
        logic        last;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [11:0] id;
        logic        last;
    } wbeat_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        req_ena = 0, req_rdy, req_write = 0;
    logic [31:0] req_addr = 0;
    logic [3:0]  req_len = 0;
    logic [11:0] req_id = 0;
    logic        wd_ena = 0, wd_rdy;
    logic [31:0] wd_v = 0;
    logic        ar_ena, ar_rdy = 1;
    logic [31:0] ar_addr;
    logic [11:0] ar_id;
    logic [3:0]  ar_len;
    logic        aw_ena, aw_rdy = 1;
    logic [31:0] aw_addr;
    logic [11:0] aw_id;
    logic [3:0]  aw_len;
    logic        w_ena, w_rdy = 1, w_last;
    logic [31:0] w_data;
    logic [11:0] w_id;
    logic        r_ena = 0, r_last = 0, r_rdy;
    logic [31:0] r_data = 0;
    logic [11:0] r_id = 0;
    logic [1:0]  r_resp = 0;
    logic        b_ena = 0, b_rdy;
    logic [11:0] b_id = 0;
    logic [1:0]  b_resp = 0;
    logic        rsp_ena, rsp_write, rsp_last, rsp_err, rsp_rdy = 1;
    logic [31:0] rsp_data;
    logic [11:0] rsp_id;
    logic        busy;
    logic [7:0]  err_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_total = 0;
    int   rsp_total = 0;
    rsp_t   exp_rsp[$];
    wbeat_t exp_w[$];

    axi_portal_initiator #(.TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_enq__ENA(req_ena), .req_enq__RDY(req_rdy), .req_enq_write(req_write),
        .req_enq_addr(req_addr), .req_enq_len(req_len), .req_enq_id(req_id),
        .wdata_enq__ENA(wd_ena), .wdata_enq__RDY(wd_rdy), .wdata_enq_v(wd_v),
        .MAXIGP0_O_AR__ENA(ar_ena), .MAXIGP0_O_AR_addr(ar_addr), .MAXIGP0_O_AR_id(ar_id),
        .MAXIGP0_O_AR_len(ar_len), .MAXIGP0_O_AR__RDY(ar_rdy),
        .MAXIGP0_O_AW__ENA(aw_ena), .MAXIGP0_O_AW_addr(aw_addr), .MAXIGP0_O_AW_id(aw_id),
        .MAXIGP0_O_AW_len(aw_len), .MAXIGP0_O_AW__RDY(aw_rdy),
        .MAXIGP0_O_W__ENA(w_ena), .MAXIGP0_O_W_data(w_data), .MAXIGP0_O_W_id(w_id),
        .MAXIGP0_O_W_last(w_last), .MAXIGP0_O_W__RDY(w_rdy),
        .MAXIGP0_I_R__ENA(r_ena), .MAXIGP0_I_R_data(r_data), .MAXIGP0_I_R_id(r_id),
        .MAXIGP0_I_R_last(r_last), .MAXIGP0_I_R_resp(r_resp), .MAXIGP0_I_R__RDY(r_rdy),
        .MAXIGP0_I_B__ENA(b_ena), .MAXIGP0_I_B_id(b_id), .MAXIGP0_I_B_resp(b_resp),
        .MAXIGP0_I_B__RDY(b_rdy),
        .rsp_enq__ENA(rsp_ena), .rsp_enq_data(rsp_data), .rsp_enq_id(rsp_id),
        .rsp_enq_write(rsp_write), .rsp_enq_last(rsp_last), .rsp_enq_err(rsp_err),
        .rsp_enq__RDY(rsp_rdy),
        .busy(busy), .errCount(err_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $error("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Scoreboard side: pop and compare on every rsp and W handshake.
    always @(negedge CLK) begin
        rsp_t   got_r, e_r;
        wbeat_t got_w, e_w;
        if (busy) busy_total++;
        if (!nRST && rsp_ena && rsp_rdy) begin
            rsp_total++;
            got_r = '{rsp_data, rsp_id, rsp_write, rsp_last, rsp_err};
            n_checks++;
            if (exp_rsp.size() == 0) begin
                n_errors++;
                $error("FAIL rsp_unexpected observed=%h expected=none", got_r);
            end else begin
                e_r = exp_rsp.pop_front();
                assert (got_r === e_r) else begin
                    n_errors++;
                    $error("FAIL rsp observed=%h expected=%h", got_r, e_r);
                end
            end
        end
        if (!nRST && w_ena && w_rdy) begin
            got_w = '{w_data, w_id, w_last};
            n_checks++;
            if (exp_w.size() == 0) begin
                n_errors++;
                $error("FAIL w_unexpected observed=%h expected=none", got_w);
            end else begin
                e_w = exp_w.pop_front();
                assert (got_w === e_w) else begin
                    n_errors++;
                    $error("FAIL w_beat observed=%h expected=%h", got_w, e_w);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [31:0] a, input logic [3:0] l,
                            input logic [11:0] id);
        int g = 0;
        req_ena = 1; req_write = wr; req_addr = a; req_len = l; req_id = id;
        @(negedge CLK);
        while (!req_rdy && g < 50) begin g++; @(negedge CLK); end
        check("req_rdy", req_rdy, 1);
        tick();
        req_ena = 0;
    endtask

    task automatic wait_addr(input logic wr, input logic [31:0] a, input logic [3:0] l,
                             input logic [11:0] id);
        int g = 0;
        @(negedge CLK);
        while (!(wr ? aw_ena : ar_ena) && g < 50) begin g++; @(negedge CLK); end
        check("addr_ena", wr ? aw_ena : ar_ena, 1);
        check("addr_addr", wr ? aw_addr : ar_addr, a);
        check("addr_len", wr ? aw_len : ar_len, l);
        check("addr_id", wr ? aw_id : ar_id, id);
        tick();
    endtask

    // Returns nb read beats; beat err_beat carries resp, beat stall_at sees rsp back-pressure.
    task automatic read_beats(input int nb, input logic [11:0] rid, input logic [31:0] base,
                              input int err_beat, input logic [1:0] resp,
                              input int stall_at, input logic [11:0] req_id_v);
        rsp_t e;
        int   g;
        for (int i = 0; i < nb; i++) begin
            e.data  = base + i;
            e.id    = rid;
            e.write = 1'b0;
            e.last  = (i == nb - 1);
            e.err   = ((i == err_beat) && (resp != 2'd0)) || (rid[5:0] != req_id_v[5:0]);
            exp_rsp.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            r_ena = 1; r_data = base + i; r_id = rid; r_last = (i == nb - 1);
            r_resp = (i == err_beat) ? resp : 2'd0;
            if (i == stall_at) begin
                rsp_rdy = 0;
                repeat (5) begin
                    @(negedge CLK);
                    check("r_rdy_stall", r_rdy, 0);
                    tick();
                end
                rsp_rdy = 1;
            end
            g = 0;
            @(negedge CLK);
            while (!r_rdy && g < 50) begin g++; @(negedge CLK); end
            check("r_rdy", r_rdy, 1);
            tick();
        end
        r_ena = 0; r_resp = 0; r_last = 0;
    endtask

    // Offers nb_drive of nb_total write beats, toggling W__RDY every cycle when toggle is set.
    task automatic write_beats(input int nb_total, input int nb_drive, input logic [11:0] id,
                               input logic toggle);
        wbeat_t e;
        int     i = 0;
        int     g = 0;
        logic   hs;
        for (int k = 0; k < nb_drive; k++) begin
            e.data = k + 1; e.id = id; e.last = (k == nb_total - 1);
            exp_w.push_back(e);
        end
        while (i < nb_drive && g < 100) begin
            wd_ena = 1; wd_v = i + 1;
            @(negedge CLK);
            hs = wd_rdy;
            check("wd_rdy_follow", wd_rdy, w_rdy);
            tick();
            if (toggle) w_rdy = ~w_rdy;
            if (hs) i++;
            g++;
        end
        check("w_beats_done", i, nb_drive);
        wd_ena = 0;
        w_rdy = 1;
    endtask

    task automatic b_resp_send(input logic [11:0] bid, input logic [1:0] resp,
                               input logic [11:0] req_id_v);
        int g = 0;
        exp_rsp.push_back('{32'd0, bid, 1'b1, 1'b1,
                            (resp != 2'd0) || (bid[5:0] != req_id_v[5:0])});
        b_ena = 1; b_id = bid; b_resp = resp;
        @(negedge CLK);
        while (!b_rdy && g < 50) begin g++; @(negedge CLK); end
        check("b_rdy", b_rdy, 1);
        tick();
        b_ena = 0; b_resp = 0;
    endtask

    initial begin
        int   busy0, rsp0, cnt, g;
        logic got;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 nRST = 0;
        @(negedge CLK);
        check("rst_req_rdy", req_rdy, 1);
        check("rst_enas", {ar_ena, aw_ena, w_ena, rsp_ena, r_rdy, b_rdy, wd_rdy}, 0);
        check("rst_busy", busy, 0);
        check("rst_errcount", err_count, 0);
        check("rst_addr", {ar_addr, w_data}, 0);
        tick();

        // Single-beat read; the responder answers one cycle after AR.
        busy0 = busy_total;
        send_req(0, 32'h0, 4'd0, 12'h005);
        wait_addr(0, 32'h0, 4'd0, 12'h005);
        tick();
        read_beats(1, 12'h005, 32'h1234, -1, 2'd0, -1, 12'h005);
        tick();
        check("read1_busy_cycles", busy_total - busy0, 3);

        // Four-beat write with W__RDY toggling
        send_req(1, 32'h10, 4'd3, 12'h00A);
        wait_addr(1, 32'h10, 4'd3, 12'h00A);
        write_beats(4, 4, 12'h00A, 1);
        b_resp_send(12'h00A, 2'd0, 12'h00A);
        tick();

        // Sixteen-beat read with rsp back-pressure mid-burst
        rsp0 = rsp_total;
        send_req(0, 32'h100, 4'd15, 12'h3A5);
        wait_addr(0, 32'h100, 4'd15, 12'h3A5);
        read_beats(16, 12'h3A5, 32'h1000, -1, 2'd0, 8, 12'h3A5);
        tick();
        check("read16_beats", rsp_total - rsp0, 16);
        check("read16_idle", busy, 0);

        // Timeout on a stuck AR channel
        check("errcount_pre_timeout", err_count, 0);
        ar_rdy = 0;
        exp_rsp.push_back('{32'hDEAD_BEEF, 12'h077, 1'b0, 1'b1, 1'b1});
        send_req(0, 32'h40, 4'd0, 12'h077);
        cnt = 0; g = 0; got = 0;
        while (g < 30 && !got) begin
            @(negedge CLK);
            if (rsp_ena) got = 1;
            else begin
                if (ar_ena) cnt++;
                tick();
            end
            g++;
        end
        check("abort_seen", got, 1);
        check("abort_ar_cycles", cnt, 8);
        check("abort_no_ar", ar_ena, 0);
        tick();
        ar_rdy = 1;
        check("errcount_after_abort", err_count, 1);
        send_req(0, 32'h44, 4'd0, 12'h078);
        wait_addr(0, 32'h44, 4'd0, 12'h078);
        read_beats(1, 12'h078, 32'h55, -1, 2'd0, -1, 12'h078);

        // Error responses: R resp and B id mismatch
        send_req(0, 32'h80, 4'd0, 12'h101);
        wait_addr(0, 32'h80, 4'd0, 12'h101);
        read_beats(1, 12'h101, 32'hABCD, 0, 2'd2, -1, 12'h101);
        send_req(1, 32'h90, 4'd0, 12'h0C3);
        wait_addr(1, 32'h90, 4'd0, 12'h0C3);
        write_beats(1, 1, 12'h0C3, 0);
        b_resp_send(12'h0C4, 2'd0, 12'h0C3);
        tick();
        check("errcount_plus2", err_count, 3);

        // Saturation
        for (int k = 0; k < 300; k++) begin
            send_req(0, k * 4, 4'd0, 12'h200);
            wait_addr(0, k * 4, 4'd0, 12'h200);
            read_beats(1, 12'h200, k, 0, 2'd2, -1, 12'h200);
            if (k == 251) begin
                tick();
                check("errcount_reach_255", err_count, 255);
            end
        end
        tick();
        check("errcount_saturated", err_count, 255);

        // Reset in the middle of a write burst
        send_req(1, 32'h200, 4'd3, 12'h0EE);
        wait_addr(1, 32'h200, 4'd3, 12'h0EE);
        write_beats(4, 2, 12'h0EE, 0);
        rsp0 = rsp_total;
        nRST = 1;
        tick();
        nRST = 0;
        @(negedge CLK);
        check("midrst_enas", {ar_ena, aw_ena, w_ena, rsp_ena}, 0);
        check("midrst_req_rdy", req_rdy, 1);
        check("midrst_busy", busy, 0);
        check("midrst_errcount", err_count, 0);
        tick();
        check("midrst_no_rsp", rsp_total - rsp0, 0);

        // Normal traffic after the reset
        send_req(0, 32'h300, 4'd1, 12'h011);
        wait_addr(0, 32'h300, 4'd1, 12'h011);
        read_beats(2, 12'h011, 32'h700, -1, 2'd0, -1, 12'h011);
        tick();
        check("rsp_queue_empty", exp_rsp.size(), 0);
        check("w_queue_empty", exp_w.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
